// File: rtl/dpe_pkg.sv
// Shared types and sizing helpers for the DPE
// control front-end.
package dpe_pkg;

  localparam int DEF_CNTW = 16;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_LOAD   = 4'b0010,
    S_STREAM = 4'b0100,
    S_DRAIN  = 4'b1000
  } state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down counter with init value and
// overflow/underflow flags.
module credit_counter #(
  parameter int W    = 5,
  parameter int MAXV = 16,
  parameter int INIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf,
  output logic         udf
);

  // simultaneous inc and dec cancel out
  assign ovf = inc && !dec && (cnt == W'(MAXV));
  assign udf = dec && !inc && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= W'(INIT);
    else if (inc && !dec && !ovf)
      cnt <= cnt + W'(1);
    else if (dec && !inc && !udf)
      cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/dpe_sequencer.sv
// Job sequencer feeding the INT8 dot product
// engine with result-FIFO credit tracking.
module dpe_sequencer
  import dpe_pkg::*;
#(
  parameter int IDATAW      = 8,
  parameter int LANES       = 164,
  parameter int BATCH       = 1,
  parameter int OFIFO_DEPTH = 16,
  parameter int CNTW        = DEF_CNTW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_reload,
  input  logic [CNTW-1:0]          cmd_num_vecs,
  input  logic signed [IDATAW-1:0] in_data [LANES],
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [IDATAW-1:0] dpe_data [LANES],
  output logic                     dpe_valid,
  output logic                     dpe_load,
  input  logic                     dpe_o_valid,
  input  logic                     out_pop,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = cnt_w(OFIFO_DEPTH);
  localparam int LW = (BATCH > 1) ? $clog2(BATCH) : 1;

  state_t          state;
  logic [CNTW-1:0] num_vecs;
  logic [CNTW-1:0] vec_cnt;
  logic [LW-1:0]   load_cnt;
  logic [CW-1:0]   credits;
  logic [CW-1:0]   inflight;
  logic            cr_ovf, cr_udf;
  logic            if_ovf, if_udf;
  logic            acc, issue;
  logic            last_load, last_vec;
  logic            drain_done;

  assign cmd_ready = !rst && (state == S_IDLE);
  assign in_ready  = !rst &&
                     ((state == S_LOAD) ||
                      ((state == S_STREAM) &&
                       (credits != '0)));
  assign busy      = (state != S_IDLE);

  assign acc       = in_valid && in_ready;
  assign issue     = acc && (state == S_STREAM);
  assign last_load = (load_cnt == LW'(BATCH - 1));
  assign last_vec  = (vec_cnt == num_vecs - CNTW'(1));

  // result arriving this cycle may retire the last one
  assign drain_done = (inflight == '0) ||
                      ((inflight == CW'(1)) && dpe_o_valid);

  credit_counter #(
    .W   (CW),
    .MAXV(OFIFO_DEPTH),
    .INIT(OFIFO_DEPTH)
  ) u_credits (
    .clk(clk),
    .rst(rst),
    .inc(out_pop),
    .dec(issue),
    .cnt(credits),
    .ovf(cr_ovf),
    .udf(cr_udf)
  );

  credit_counter #(
    .W   (CW),
    .MAXV(OFIFO_DEPTH),
    .INIT(0)
  ) u_inflight (
    .clk(clk),
    .rst(rst),
    .inc(issue),
    .dec(dpe_o_valid),
    .cnt(inflight),
    .ovf(if_ovf),
    .udf(if_udf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      num_vecs  <= '0;
      vec_cnt   <= '0;
      load_cnt  <= '0;
      dpe_valid <= 1'b0;
      dpe_load  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      dpe_valid <= acc;
      dpe_load  <= acc && (state == S_LOAD);
      done      <= 1'b0;
      if (cr_ovf || cr_udf || if_ovf || if_udf)
        err <= 1'b1;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (cmd_valid) begin
            num_vecs <= cmd_num_vecs;
            vec_cnt  <= '0;
            load_cnt <= '0;
            if (cmd_reload)
              state <= S_LOAD;
            else if (cmd_num_vecs != '0)
              state <= S_STREAM;
            else begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        (state == S_LOAD): begin
          if (acc) begin
            load_cnt <= load_cnt + LW'(1);
            if (last_load)
              state <= (num_vecs != '0) ?
                       S_STREAM : S_DRAIN;
          end
        end
        (state == S_STREAM): begin
          if (acc) begin
            vec_cnt <= vec_cnt + CNTW'(1);
            if (last_vec)
              state <= S_DRAIN;
          end
        end
        (state == S_DRAIN): begin
          if (drain_done) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      dpe_data <= '{default: '0};
    else if (acc)
      dpe_data <= in_data;
  end

endmodule
